// File: rtl/overlay_pkg.sv
// Shared types and constants for the font overlay engine.
package overlay_pkg;

  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 64;
  localparam int FONT_AW = 10;
  localparam int RGB_W   = 24;

  typedef logic [RGB_W-1:0] rgb_t;

  typedef enum logic {
    WAIT_FRAME = 1'b0,
    ACTIVE     = 1'b1
  } frame_state_t;

endpackage

// File: rtl/overlay_sync_delay.sv
// N-stage register delay of video timing and pixel data, so they line up
// with the overlay pipeline output.
module overlay_sync_delay
  import overlay_pkg::*;
#(
  parameter int N = 3
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_de,
  input  logic i_hsync,
  input  logic i_vsync,
  input  rgb_t i_rgb,
  output logic o_de,
  output logic o_hsync,
  output logic o_vsync,
  output rgb_t o_rgb
);

  logic [N-1:0] r_de;
  logic [N-1:0] r_hsync;
  logic [N-1:0] r_vsync;
  rgb_t         r_rgb [N];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_de    <= '0;
      r_hsync <= '0;
      r_vsync <= '0;
      for (int i = 0; i < N; i++) r_rgb[i] <= '0;
    end else begin
      r_de[0]    <= i_de;
      r_hsync[0] <= i_hsync;
      r_vsync[0] <= i_vsync;
      r_rgb[0]   <= i_rgb;
      for (int i = 1; i < N; i++) begin
        r_de[i]    <= r_de[i-1];
        r_hsync[i] <= r_hsync[i-1];
        r_vsync[i] <= r_vsync[i-1];
        r_rgb[i]   <= r_rgb[i-1];
      end
    end
  end

  assign o_de    = r_de[N-1];
  assign o_hsync = r_hsync[N-1];
  assign o_vsync = r_vsync[N-1];
  assign o_rgb   = r_rgb[N-1];

endmodule

// File: rtl/font_overlay_engine.sv
// Overlays one 8x64 font glyph (scaled by 2^SCALE_LOG2) onto the video stream
// with a fixed 3-cycle latency. Optional macro: OVERLAY_TRANSPARENT_BG_EN.
module font_overlay_engine
  import overlay_pkg::*;
#(
  parameter logic [10:0] BOX_X      = 11'd64,
  parameter logic [10:0] BOX_Y      = 11'd64,
  parameter int          SCALE_LOG2 = 2,
  parameter rgb_t        FG_COLOR   = 24'hFFFFFF,
  parameter rgb_t        BG_COLOR   = 24'h000000
) (
  input  logic               clk_50MHz,
  input  logic               reset,
  input  logic [FONT_AW-1:0] offset,
  input  logic [10:0]        hcount,
  input  logic [10:0]        vcount,
  input  logic               de_in,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  rgb_t               rgb_in,
  output logic [FONT_AW-1:0] rom_addr,
  input  logic [7:0]         rom_data,
  output logic               de_out,
  output logic               hsync_out,
  output logic               vsync_out,
  output rgb_t               rgb_out
);

  localparam logic [10:0] BOX_W = 11'(GLYPH_W << SCALE_LOG2);
  localparam logic [10:0] BOX_H = 11'(GLYPH_H << SCALE_LOG2);

  frame_state_t       r_state;
  logic               r_vsync_d;
  logic [FONT_AW-1:0] r_glyph_base;

  logic               r_in_box0, r_in_box1, r_in_box2;
  logic [2:0]         r_col0, r_col1;
  logic               r_fg2;

  logic [10:0]        w_hrel, w_vrel;
  logic [2:0]         w_col;
  logic [5:0]         w_row;
  logic               w_in_box;
  logic               w_de_d, w_hsync_d, w_vsync_d;
  rgb_t               w_rgb_d, w_bg, w_pix;

  // Glyph base only moves on a vsync rising edge, so a frame never tears.
  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      r_state      <= WAIT_FRAME;
      r_vsync_d    <= 1'b1;
      r_glyph_base <= '0;
    end else begin
      r_vsync_d <= vsync_in;
      if (vsync_in && !r_vsync_d) begin
        r_glyph_base <= offset;
        r_state      <= ACTIVE;
      end
    end
  end

  assign w_hrel   = hcount - BOX_X;
  assign w_vrel   = vcount - BOX_Y;
  assign w_col    = 3'(w_hrel >> SCALE_LOG2);
  assign w_row    = 6'(w_vrel >> SCALE_LOG2);
  assign w_in_box = de_in && (r_state == ACTIVE)
                    && (hcount >= BOX_X) && (w_hrel < BOX_W)
                    && (vcount >= BOX_Y) && (w_vrel < BOX_H);

  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      rom_addr  <= '0;
      r_in_box0 <= 1'b0;
      r_col0    <= '0;
      r_in_box1 <= 1'b0;
      r_col1    <= '0;
      r_in_box2 <= 1'b0;
      r_fg2     <= 1'b0;
    end else begin
      rom_addr  <= r_glyph_base + {4'b0, w_row};
      r_in_box0 <= w_in_box;
      r_col0    <= w_col;
      r_in_box1 <= r_in_box0;
      r_col1    <= r_col0;
      r_in_box2 <= r_in_box1;
      r_fg2     <= r_in_box1 && rom_data[3'd7 - r_col1];
    end
  end

  overlay_sync_delay #(.N(3)) u_sync_delay (
    .i_clk   (clk_50MHz),
    .i_reset (reset),
    .i_de    (de_in),
    .i_hsync (hsync_in),
    .i_vsync (vsync_in),
    .i_rgb   (rgb_in),
    .o_de    (w_de_d),
    .o_hsync (w_hsync_d),
    .o_vsync (w_vsync_d),
    .o_rgb   (w_rgb_d)
  );

`ifdef OVERLAY_TRANSPARENT_BG_EN
  assign w_bg = w_rgb_d;
`else
  assign w_bg = BG_COLOR;
`endif

  always_comb begin
    w_pix = w_rgb_d;
    if (r_in_box2) w_pix = r_fg2 ? FG_COLOR : w_bg;
  end

  assign de_out    = w_de_d;
  assign hsync_out = w_hsync_d;
  assign vsync_out = w_vsync_d;
  assign rgb_out   = w_de_d ? w_pix : '0;

endmodule

// File: tb/tb_font_overlay_engine.sv
// Directed bench for font_overlay_engine: two instances (scale 1x and 4x)
// share the video inputs; each has its own font ROM model.
module tb_font_overlay_engine;

  localparam logic [23:0] FG  = 24'hFFFFFF;
  localparam logic [23:0] PIX = 24'h123456;
`ifdef OVERLAY_TRANSPARENT_BG_EN
  localparam logic [23:0] BGX = PIX;
`else
  localparam logic [23:0] BGX = 24'h000000;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  offset;
  logic [10:0] hcount, vcount;
  logic        deIn, hsyncIn, vsyncIn;
  logic [23:0] rgbIn;

  logic [9:0]  romAddr0, romAddr2;
  logic [7:0]  romData0, romData2;
  logic        deOut0, hsyncOut0, vsyncOut0;
  logic        deOut2, hsyncOut2, vsyncOut2;
  logic [23:0] rgbOut0, rgbOut2;

  int checkCount = 0;
  int passCount  = 0;

  logic [23:0] got0 [16];
  logic [23:0] got2 [16];
  logic        gotDe0 [16];

  always #10 clk = ~clk;

  // Font ROM: row byte = low address byte XOR 0x25, so 0x080 holds 0xA5.
  always @(posedge clk) begin
    romData0 <= romAddr0[7:0] ^ 8'h25;
    romData2 <= romAddr2[7:0] ^ 8'h25;
  end

  font_overlay_engine #(.SCALE_LOG2(0)) dut0 (
    .clk_50MHz (clk),      .reset     (reset),     .offset   (offset),
    .hcount    (hcount),   .vcount    (vcount),    .de_in    (deIn),
    .hsync_in  (hsyncIn),  .vsync_in  (vsyncIn),   .rgb_in   (rgbIn),
    .rom_addr  (romAddr0), .rom_data  (romData0),  .de_out   (deOut0),
    .hsync_out (hsyncOut0), .vsync_out (vsyncOut0), .rgb_out (rgbOut0)
  );

  font_overlay_engine #(.SCALE_LOG2(2)) dut2 (
    .clk_50MHz (clk),      .reset     (reset),     .offset   (offset),
    .hcount    (hcount),   .vcount    (vcount),    .de_in    (deIn),
    .hsync_in  (hsyncIn),  .vsync_in  (vsyncIn),   .rgb_in   (rgbIn),
    .rom_addr  (romAddr2), .rom_data  (romData2),  .de_out   (deOut2),
    .hsync_out (hsyncOut2), .vsync_out (vsyncOut2), .rgb_out (rgbOut2)
  );

  // Drives n consecutive pixels of one line and captures each output 3 cycles later.
  task automatic streamLine(input int v, input int h0, input int n,
                            input logic [23:0] rgb, input logic de);
    for (int i = 0; i < n + 3; i++) begin
      @(posedge clk); #1;
      if (i >= 3) begin
        got0[i-3]   = rgbOut0;
        got2[i-3]   = rgbOut2;
        gotDe0[i-3] = deOut0;
      end
      if (i < n) begin
        hcount = 11'(h0 + i);
        vcount = 11'(v);
        deIn   = de;
        rgbIn  = rgb;
      end else begin
        deIn  = 1'b0;
        rgbIn = 24'h0;
      end
    end
  endtask

  // Offset changes on the same cycle vsync rises.
  task automatic vsyncPulse(input logic [9:0] off);
    @(posedge clk); #1;
    deIn    = 1'b0;
    offset  = off;
    vsyncIn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vsyncIn = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; offset = 10'h000; hcount = 11'd64; vcount = 11'd64;
    deIn = 1'b1; hsyncIn = 1'b1; vsyncIn = 1'b0; rgbIn = PIX;
    repeat (4) @(posedge clk);
    #1;
    checkCount++;
    if (rgbOut0 !== 24'h0) $display("[TB] FAIL reset_rgb0: got %h expected %h", rgbOut0, 24'h0);
    else passCount++;
    checkCount++;
    if (rgbOut2 !== 24'h0) $display("[TB] FAIL reset_rgb2: got %h expected %h", rgbOut2, 24'h0);
    else passCount++;
    checkCount++;
    if ({deOut0, hsyncOut0, vsyncOut0} !== 3'b000)
      $display("[TB] FAIL reset_sync: got %b expected %b", {deOut0, hsyncOut0, vsyncOut0}, 3'b000);
    else passCount++;
    checkCount++;
    if (romAddr0 !== 10'h000) $display("[TB] FAIL reset_romaddr: got %h expected %h", romAddr0, 10'h000);
    else passCount++;
    deIn = 1'b0; hsyncIn = 1'b0; rgbIn = 24'h0;
    @(posedge clk); #3;
    reset = 1'b0;
  endtask

  task automatic test_wait_frame;
    streamLine(64, 64, 8, PIX, 1'b1);
    for (int i = 0; i < 8; i += 7) begin
      checkCount++;
      if (got0[i] !== PIX) $display("[TB] FAIL wait_rgb0[%0d]: got %h expected %h", i, got0[i], PIX);
      else passCount++;
      checkCount++;
      if (got2[i] !== PIX) $display("[TB] FAIL wait_rgb2[%0d]: got %h expected %h", i, got2[i], PIX);
      else passCount++;
    end
    checkCount++;
    if (gotDe0[0] !== 1'b1) $display("[TB] FAIL wait_de: got %b expected %b", gotDe0[0], 1'b1);
    else passCount++;
    streamLine(64, 64, 1, PIX, 1'b0);
    checkCount++;
    if (got0[0] !== 24'h0) $display("[TB] FAIL de_low_blank: got %h expected %h", got0[0], 24'h0);
    else passCount++;
    checkCount++;
    if (gotDe0[0] !== 1'b0) $display("[TB] FAIL de_low_de: got %b expected %b", gotDe0[0], 1'b0);
    else passCount++;
    @(posedge clk); #1; hsyncIn = 1'b1;
    @(posedge clk); #1; hsyncIn = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkCount++;
    if (hsyncOut0 !== 1'b1) $display("[TB] FAIL hsync_delay_hi: got %b expected %b", hsyncOut0, 1'b1);
    else passCount++;
    @(posedge clk); #1;
    checkCount++;
    if (hsyncOut0 !== 1'b0) $display("[TB] FAIL hsync_delay_lo: got %b expected %b", hsyncOut0, 1'b0);
    else passCount++;
  endtask

  task automatic test_glyph_line;
    logic [23:0] exp0 [12];
    logic [23:0] exp2 [12];
    exp0 = '{PIX, PIX, FG, BGX, FG, BGX, BGX, FG, BGX, FG, PIX, PIX};
    exp2 = '{PIX, PIX, FG, FG, FG, FG, BGX, BGX, BGX, BGX, FG, FG};
    vsyncPulse(10'h080);
    streamLine(64, 62, 12, PIX, 1'b1);
    for (int i = 0; i < 12; i++) begin
      checkCount++;
      if (got0[i] !== exp0[i]) $display("[TB] FAIL glyph_s0[%0d]: got %h expected %h", i, got0[i], exp0[i]);
      else passCount++;
      checkCount++;
      if (got2[i] !== exp2[i]) $display("[TB] FAIL glyph_s2[%0d]: got %h expected %h", i, got2[i], exp2[i]);
      else passCount++;
    end
  endtask

  task automatic test_offset_change;
    logic [23:0] expOld [8];
    logic [23:0] expNew [8];
    expOld = '{FG, BGX, FG, BGX, BGX, FG, BGX, BGX};
    expNew = '{FG, FG, FG, BGX, BGX, FG, BGX, BGX};
    offset = 10'h0C0;
    streamLine(65, 64, 8, PIX, 1'b1);
    for (int i = 0; i < 8; i++) begin
      checkCount++;
      if (got0[i] !== expOld[i]) $display("[TB] FAIL offset_hold[%0d]: got %h expected %h", i, got0[i], expOld[i]);
      else passCount++;
    end
    checkCount++;
    if (got2[4] !== BGX) $display("[TB] FAIL offset_hold_s2: got %h expected %h", got2[4], BGX);
    else passCount++;
    vsyncPulse(10'h0C0);
    streamLine(65, 64, 8, PIX, 1'b1);
    for (int i = 0; i < 8; i++) begin
      checkCount++;
      if (got0[i] !== expNew[i]) $display("[TB] FAIL offset_new[%0d]: got %h expected %h", i, got0[i], expNew[i]);
      else passCount++;
    end
    checkCount++;
    if (got2[4] !== FG) $display("[TB] FAIL offset_new_s2: got %h expected %h", got2[4], FG);
    else passCount++;
  endtask

  task automatic test_rom_wrap;
    vsyncPulse(10'h3C0);
    @(posedge clk); #1;
    hcount = 11'd64; vcount = 11'd127; deIn = 1'b1; rgbIn = PIX;
    @(posedge clk); #1;
    deIn = 1'b0;
    checkCount++;
    if (romAddr0 !== 10'h3FF) $display("[TB] FAIL rom_addr_row63: got %h expected %h", romAddr0, 10'h3FF);
    else passCount++;
    checkCount++;
    if (romAddr2 !== 10'h3CF) $display("[TB] FAIL rom_addr_s2_row15: got %h expected %h", romAddr2, 10'h3CF);
    else passCount++;
    vsyncPulse(10'h3FF);
    @(posedge clk); #1;
    hcount = 11'd64; vcount = 11'd65; deIn = 1'b1; rgbIn = PIX;
    @(posedge clk); #1;
    deIn = 1'b0;
    checkCount++;
    if (romAddr0 !== 10'h000) $display("[TB] FAIL rom_addr_wrap: got %h expected %h", romAddr0, 10'h000);
    else passCount++;
    checkCount++;
    if (romAddr2 !== 10'h3FF) $display("[TB] FAIL rom_addr_s2_base: got %h expected %h", romAddr2, 10'h3FF);
    else passCount++;
    streamLine(65, 66, 1, PIX, 1'b1);
    checkCount++;
    if (got0[0] !== FG) $display("[TB] FAIL wrap_pixel: got %h expected %h", got0[0], FG);
    else passCount++;
  endtask

  task automatic test_scale;
    vsyncPulse(10'h080);
    streamLine(312, 92, 5, PIX, 1'b1);
    checkCount++;
    if (got2[3] !== FG) $display("[TB] FAIL scale_last_col: got %h expected %h", got2[3], FG);
    else passCount++;
    checkCount++;
    if (got2[4] !== PIX) $display("[TB] FAIL scale_right_edge: got %h expected %h", got2[4], PIX);
    else passCount++;
    checkCount++;
    if (got0[3] !== PIX) $display("[TB] FAIL scale0_below_box: got %h expected %h", got0[3], PIX);
    else passCount++;
    streamLine(313, 64, 5, PIX, 1'b1);
    checkCount++;
    if (got2[3] !== FG) $display("[TB] FAIL scale_rep_col: got %h expected %h", got2[3], FG);
    else passCount++;
    checkCount++;
    if (got2[4] !== BGX) $display("[TB] FAIL scale_next_col: got %h expected %h", got2[4], BGX);
    else passCount++;
    streamLine(319, 64, 1, PIX, 1'b1);
    checkCount++;
    if (got2[0] !== FG) $display("[TB] FAIL scale_last_line: got %h expected %h", got2[0], FG);
    else passCount++;
    streamLine(320, 64, 1, PIX, 1'b1);
    checkCount++;
    if (got2[0] !== PIX) $display("[TB] FAIL scale_bottom_edge: got %h expected %h", got2[0], PIX);
    else passCount++;
  endtask

  task automatic test_reset_midframe;
    vsyncPulse(10'h080);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      hcount = 11'(64 + i); vcount = 11'd64; deIn = 1'b1; rgbIn = PIX;
    end
    checkCount++;
    if (rgbOut0 !== FG) $display("[TB] FAIL midframe_pre: got %h expected %h", rgbOut0, FG);
    else passCount++;
    #2;
    reset = 1'b1;
    vsyncIn = 1'b1;
    #1;
    checkCount++;
    if (rgbOut0 !== 24'h0) $display("[TB] FAIL midframe_rgb0: got %h expected %h", rgbOut0, 24'h0);
    else passCount++;
    checkCount++;
    if (rgbOut2 !== 24'h0) $display("[TB] FAIL midframe_rgb2: got %h expected %h", rgbOut2, 24'h0);
    else passCount++;
    checkCount++;
    if ({deOut0, romAddr0} !== 11'h0) $display("[TB] FAIL midframe_de_addr: got %h expected %h", {deOut0, romAddr0}, 11'h0);
    else passCount++;
    @(posedge clk); #3;
    reset = 1'b0;
    streamLine(64, 64, 8, PIX, 1'b1);
    checkCount++;
    if (got0[0] !== PIX) $display("[TB] FAIL after_reset_vs_high: got %h expected %h", got0[0], PIX);
    else passCount++;
    checkCount++;
    if (got2[0] !== PIX) $display("[TB] FAIL after_reset_vs_high_s2: got %h expected %h", got2[0], PIX);
    else passCount++;
    vsyncIn = 1'b0;
    streamLine(64, 64, 8, PIX, 1'b1);
    checkCount++;
    if (got0[0] !== PIX) $display("[TB] FAIL after_reset_no_edge: got %h expected %h", got0[0], PIX);
    else passCount++;
    vsyncPulse(10'h080);
    streamLine(64, 64, 8, PIX, 1'b1);
    checkCount++;
    if (got0[0] !== FG) $display("[TB] FAIL after_reset_glyph_fg: got %h expected %h", got0[0], FG);
    else passCount++;
    checkCount++;
    if (got0[1] !== BGX) $display("[TB] FAIL after_reset_glyph_bg: got %h expected %h", got0[1], BGX);
    else passCount++;
    checkCount++;
    if (got2[0] !== FG) $display("[TB] FAIL after_reset_glyph_s2: got %h expected %h", got2[0], FG);
    else passCount++;
  endtask

  initial begin
    test_reset;
    test_wait_frame;
    test_glyph_line;
    test_offset_change;
    test_rom_wrap;
    test_scale;
    test_reset_midframe;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
